// File: rtl/vga_sync_detect.sv
// Receive-side VGA timing checker: measures incoming hsync/vsync timing, locks onto the
// expected mode after a run of good frames, and regenerates data-enable and pixel coordinates.
module vga_sync_detect #(
    parameter int H_VIDEO     = 640,
    parameter int H_FRONTP    = 16,
    parameter int H_PULSE     = 96,
    parameter int H_BACKP     = 48,
    parameter int V_VIDEO     = 480,
    parameter int V_FRONTP    = 11,
    parameter int V_PULSE     = 2,
    parameter int V_BACKP     = 31,
    parameter int H_TOL       = 2,
    parameter int LOCK_FRAMES = 2,
    parameter int CW          = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          h_sync_in,
    input  logic          v_sync_in,
    output logic          locked,
    output logic          de,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          frame_start,
    output logic [CW-1:0] h_total_meas,
    output logic [CW-1:0] h_pulse_meas,
    output logic [CW-1:0] v_total_meas,
    output logic [CW-1:0] v_pulse_meas
);

    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [CW-1:0] CNT_MAX_C = {CW{1'b1}};
    localparam logic [CW-1:0] H_LO_C    = CW'(H_VIDEO + H_FRONTP + H_PULSE + H_BACKP - H_TOL);
    localparam logic [CW-1:0] H_HI_C    = CW'(H_VIDEO + H_FRONTP + H_PULSE + H_BACKP + H_TOL);
    localparam logic [CW-1:0] P_LO_C    = CW'(H_PULSE - H_TOL);
    localparam logic [CW-1:0] P_HI_C    = CW'(H_PULSE + H_TOL);
    localparam logic [CW-1:0] V_SUM_C   = CW'(V_VIDEO + V_FRONTP + V_PULSE + V_BACKP);
    localparam logic [CW-1:0] V_PULSE_C = CW'(V_PULSE);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(2 * (H_VIDEO + H_FRONTP + H_PULSE + H_BACKP));
    localparam logic [CW-1:0] H_START_C = CW'(H_PULSE + H_BACKP);
    localparam logic [CW-1:0] H_END_C   = CW'(H_PULSE + H_BACKP + H_VIDEO - 1);
    localparam logic [CW-1:0] V_START_C = CW'(V_PULSE + V_BACKP);
    localparam logic [CW-1:0] V_END_C   = CW'(V_PULSE + V_BACKP + V_VIDEO - 1);
    localparam logic [CW-1:0] LOCK_C    = CW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH,
        TRACK,
        LOCKED
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] good_cnt_q, good_cnt_d;
    logic          frame_ok_q, frame_ok_d;

    logic          h_meta_q, h_sync_q, h_dly_q;
    logic          v_meta_q, v_sync_q, v_dly_q;
    logic          h_fall, h_rise, v_fall, v_rise;

    logic [CW-1:0] h_cnt_q, v_cnt_q;
    logic [CW-1:0] h_total_q, h_pulse_q, v_total_q, v_pulse_q;
    logic          frame_start_q;
    logic          de_q, de_d;
    logic [CW-1:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;

    logic [CW-1:0] h_tot_new, v_tot_new;
    logic          line_good, lines_ok, frame_good, timeout;

    // Counters stick at all-ones so a dead input cannot wrap back into a plausible value.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (x == CNT_MAX_C) ? x : x + ONE_C;
    endfunction

    assign h_fall = h_dly_q & ~h_sync_q;
    assign h_rise = ~h_dly_q & h_sync_q;
    assign v_fall = v_dly_q & ~v_sync_q;
    assign v_rise = ~v_dly_q & v_sync_q;

    // Two-flop synchronizers followed by an edge-detect register for both sync inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_meta_q <= 1'b1;
            h_sync_q <= 1'b1;
            h_dly_q  <= 1'b1;
            v_meta_q <= 1'b1;
            v_sync_q <= 1'b1;
            v_dly_q  <= 1'b1;
        end else begin
            h_meta_q <= h_sync_in;
            h_sync_q <= h_meta_q;
            h_dly_q  <= h_sync_q;
            v_meta_q <= v_sync_in;
            v_sync_q <= v_meta_q;
            v_dly_q  <= v_sync_q;
        end
    end

    // Judge the line closing on this hsync fall and the frame closing on this vsync fall.
    always_comb begin
        h_tot_new  = sat_inc(h_cnt_q);
        v_tot_new  = sat_inc(v_cnt_q);
        line_good  = (h_tot_new >= H_LO_C) && (h_tot_new <= H_HI_C) &&
                     (h_pulse_q >= P_LO_C) && (h_pulse_q <= P_HI_C);
        lines_ok   = frame_ok_q && (!h_fall || line_good);
        frame_good = lines_ok && (v_tot_new == V_SUM_C) && (v_pulse_q == V_PULSE_C);
        timeout    = (h_cnt_q >= TIMEOUT_C) && !h_fall;
        frame_ok_d = v_fall ? 1'b1 : lines_ok;
    end

    // Lock state machine: a lost hsync overrides everything, otherwise decide at each vsync fall.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        if (timeout) begin
            state_d    = SEARCH;
            good_cnt_d = '0;
        end else if (v_fall) begin
            case (state_q)
                SEARCH: begin
                    state_d    = TRACK;
                    good_cnt_d = '0;
                end
                TRACK: begin
                    if (frame_good) begin
                        good_cnt_d = good_cnt_q + ONE_C;
                        if (good_cnt_q + ONE_C >= LOCK_C) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (!frame_good) begin
                        state_d    = SEARCH;
                        good_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = SEARCH;
                    good_cnt_d = '0;
                end
            endcase
        end
    end

    // Video window uses the next lock state so de drops on the same clock that locked does.
    always_comb begin
        de_d      = 1'b0;
        pixel_x_d = '0;
        pixel_y_d = '0;
        if ((state_d == LOCKED) && (h_cnt_q >= H_START_C) && (h_cnt_q <= H_END_C) &&
            (v_cnt_q >= V_START_C) && (v_cnt_q <= V_END_C)) begin
            de_d      = 1'b1;
            pixel_x_d = h_cnt_q - H_START_C;
            pixel_y_d = v_cnt_q - V_START_C;
        end
    end

    // Line/frame counters, timing measurements and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= SEARCH;
            good_cnt_q    <= '0;
            frame_ok_q    <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            h_total_q     <= '0;
            h_pulse_q     <= '0;
            v_total_q     <= '0;
            v_pulse_q     <= '0;
            frame_start_q <= 1'b0;
            de_q          <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
        end else begin
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            frame_ok_q    <= frame_ok_d;
            frame_start_q <= v_fall;
            de_q          <= de_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            if (h_fall) begin
                h_cnt_q   <= '0;
                h_total_q <= h_tot_new;
            end else begin
                h_cnt_q <= sat_inc(h_cnt_q);
            end
            if (h_rise) begin
                h_pulse_q <= h_tot_new;
            end
            if (v_fall) begin
                v_cnt_q   <= '0;
                v_total_q <= v_tot_new;
            end else if (h_fall) begin
                v_cnt_q <= sat_inc(v_cnt_q);
            end
            if (v_rise) begin
                v_pulse_q <= v_tot_new;
            end
        end
    end

    assign locked       = (state_q == LOCKED);
    assign de           = de_q;
    assign pixel_x      = pixel_x_q;
    assign pixel_y      = pixel_y_q;
    assign frame_start  = frame_start_q;
    assign h_total_meas = h_total_q;
    assign h_pulse_meas = h_pulse_q;
    assign v_total_meas = v_total_q;
    assign v_pulse_meas = v_pulse_q;

endmodule

// File: tb/tb_vga_sync_detect.sv
// Testbench for vga_sync_detect using a shrunken video mode so whole frames fit a short run.
module tb_vga_sync_detect;

    localparam int HV = 16, HF = 4, HP = 8, HB = 4;
    localparam int VV = 8,  VF = 2, VP = 2, VB = 3;
    localparam int TOL = 2, LOCKF = 2, CW = 12;
    localparam int HSUM = HV + HF + HP + HB;
    localparam int VSUM = VV + VF + VP + VB;
    localparam int MAXL = VSUM + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          hSyncIn, vSyncIn;
    logic          locked, de, frameStart;
    logic [CW-1:0] pixelX, pixelY, hTotalMeas, hPulseMeas, vTotalMeas, vPulseMeas;

    typedef struct {
        bit lockedExp;
        bit measKnown;
        int hTot;
        int hPul;
        int vTot;
        int vPul;
        bit deKnown;
        int deExp;
    } expRec_t;

    expRec_t expQ[$];

    int checks = 0;
    int failures = 0;

    int lineLen[MAXL];
    int linePul[MAXL];
    int frameLines, frameVpul;

    bit prevValid = 1'b0, prevGood = 1'b0;
    int prevLastLen, prevLastPul, prevLines, prevVpul;
    bit acquired = 1'b0, deTrust = 1'b1;
    int goodRun = 0;

    int deCnt = 0, firstX = 0, firstY = 0, lastX = 0, lastY = 0;
    bit seenDe = 1'b0;

    vga_sync_detect #(
        .H_VIDEO(HV), .H_FRONTP(HF), .H_PULSE(HP), .H_BACKP(HB),
        .V_VIDEO(VV), .V_FRONTP(VF), .V_PULSE(VP), .V_BACKP(VB),
        .H_TOL(TOL), .LOCK_FRAMES(LOCKF), .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .h_sync_in(hSyncIn),
        .v_sync_in(vSyncIn),
        .locked(locked),
        .de(de),
        .pixel_x(pixelX),
        .pixel_y(pixelY),
        .frame_start(frameStart),
        .h_total_meas(hTotalMeas),
        .h_pulse_meas(hPulseMeas),
        .v_total_meas(vTotalMeas),
        .v_pulse_meas(vPulseMeas)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit modelLocked();
        return acquired && (goodRun >= LOCKF);
    endfunction

    function automatic bit modelFrameGood();
        bit ok;
        ok = (frameLines == VSUM) && (frameVpul == VP);
        for (int i = 0; i < frameLines; i++) begin
            if (lineLen[i] > HSUM + TOL || lineLen[i] < HSUM - TOL) ok = 1'b0;
            if (linePul[i] > HP + TOL || linePul[i] < HP - TOL) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic genFrame(input int mode);
        int idx;
        frameLines = VSUM;
        frameVpul  = VP;
        for (int i = 0; i < MAXL; i++) begin
            lineLen[i] = HSUM;
            linePul[i] = HP;
        end
        idx = int'($urandom_range(0, VSUM - 1));
        case (mode)
            1: for (int i = 0; i < VSUM; i++) begin
                   lineLen[i] = HSUM + int'($urandom_range(0, 2 * TOL)) - TOL;
                   linePul[i] = HP + int'($urandom_range(0, 2 * TOL)) - TOL;
               end
            2: lineLen[idx] = HSUM + TOL + 1;
            3: linePul[idx] = ($urandom_range(0, 1) == 0) ? HP + TOL + 1 : HP - TOL - 1;
            4: frameLines = VSUM + 1;
            5: frameVpul = VP + 1;
            6: lineLen[idx] = HSUM + 1;
            7: lineLen[idx] = HSUM + 10;
            default: ;
        endcase
    endtask

    // Record what the DUT must show at the frame_start caused by the vsync fall being driven now.
    task automatic pushExpected();
        expRec_t e;
        e.measKnown = prevValid;
        e.hTot      = prevLastLen;
        e.hPul      = prevLastPul;
        e.vTot      = prevLines;
        e.vPul      = prevVpul;
        e.deKnown   = deTrust;
        e.deExp     = (modelLocked() && prevValid) ? HV * VV : 0;
        if (!acquired) begin
            acquired = 1'b1;
            goodRun  = 0;
        end else if (prevValid && prevGood) begin
            goodRun++;
        end else begin
            if (modelLocked()) acquired = 1'b0;
            goodRun = 0;
        end
        e.lockedExp = modelLocked();
        deTrust     = 1'b1;
        expQ.push_back(e);
    endtask

    // Drive one frame (or its first nDrive lines) of the requested kind onto the sync pins.
    task automatic applyStimulus(input int mode, input int nDrive);
        int n;
        genFrame(mode);
        n = (nDrive < frameLines) ? nDrive : frameLines;
        for (int i = 0; i < n; i++) begin
            if (i == 0) pushExpected();
            hSyncIn = 1'b0;
            if (i == 0) vSyncIn = 1'b0;
            if (i == frameVpul) vSyncIn = 1'b1;
            waitClocks(linePul[i]);
            hSyncIn = 1'b1;
            waitClocks(lineLen[i] - linePul[i]);
        end
        if (n == frameLines) begin
            prevValid   = 1'b1;
            prevGood    = modelFrameGood();
            prevLastLen = lineLen[frameLines - 1];
            prevLastPul = linePul[frameLines - 1];
            prevLines   = frameLines;
            prevVpul    = frameVpul;
        end else begin
            prevValid = 1'b0;
        end
    endtask

    task automatic checkAllClear(input string tag);
        checkOutput({tag, "_locked"}, int'(locked), 0);
        checkOutput({tag, "_de"}, int'(de), 0);
        checkOutput({tag, "_pixel_x"}, int'(pixelX), 0);
        checkOutput({tag, "_pixel_y"}, int'(pixelY), 0);
        checkOutput({tag, "_frame_start"}, int'(frameStart), 0);
        checkOutput({tag, "_h_total"}, int'(hTotalMeas), 0);
        checkOutput({tag, "_h_pulse"}, int'(hPulseMeas), 0);
        checkOutput({tag, "_v_total"}, int'(vTotalMeas), 0);
        checkOutput({tag, "_v_pulse"}, int'(vPulseMeas), 0);
    endtask

    // Monitor: tracks de activity and settles each scoreboard entry when frame_start appears.
    always @(negedge clk) begin
        if (!rst) begin
            deCnt  = 0;
            seenDe = 1'b0;
        end else begin
            if (de) begin
                checkOutput("de_requires_lock", int'(locked), 1);
                if (!seenDe) begin
                    firstX = int'(pixelX);
                    firstY = int'(pixelY);
                end
                lastX  = int'(pixelX);
                lastY  = int'(pixelY);
                seenDe = 1'b1;
                deCnt++;
            end else begin
                checkOutput("pixel_zero_when_idle", int'(pixelX) + int'(pixelY), 0);
            end
            if (frameStart) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_frame_start", int'(frameStart), 0);
                end else begin
                    expRec_t e;
                    e = expQ.pop_front();
                    checkOutput("locked_at_frame", int'(locked), int'(e.lockedExp));
                    if (e.measKnown) begin
                        checkOutput("h_total_meas", int'(hTotalMeas), e.hTot);
                        checkOutput("h_pulse_meas", int'(hPulseMeas), e.hPul);
                        checkOutput("v_total_meas", int'(vTotalMeas), e.vTot);
                        checkOutput("v_pulse_meas", int'(vPulseMeas), e.vPul);
                    end
                    if (e.deKnown) begin
                        checkOutput("de_count", deCnt, e.deExp);
                        if (e.deExp > 0) begin
                            checkOutput("first_pixel_x", firstX, 0);
                            checkOutput("first_pixel_y", firstY, 0);
                            checkOutput("last_pixel_x", lastX, HV - 1);
                            checkOutput("last_pixel_y", lastY, VV - 1);
                        end
                    end
                end
                deCnt  = 0;
                seenDe = 1'b0;
            end
        end
    end

    // Watchdog so a stuck run still reports before stopping.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Main stimulus sequence.
    initial begin
        rst     = 1'b0;
        hSyncIn = 1'b1;
        vSyncIn = 1'b1;

        for (int i = 0; i < 40; i++) begin
            waitClocks(1);
            hSyncIn = 1'($urandom_range(0, 1));
            vSyncIn = 1'($urandom_range(0, 1));
        end
        checkAllClear("in_reset");
        hSyncIn = 1'b1;
        vSyncIn = 1'b1;
        waitClocks(2);
        rst = 1'b1;
        waitClocks(5);
        checkOutput("locked_after_release", int'(locked), 0);

        for (int f = 0; f < 4; f++) applyStimulus(0, MAXL);
        applyStimulus(6, MAXL);
        applyStimulus(7, MAXL);
        applyStimulus(0, MAXL);
        for (int f = 0; f < 14; f++) applyStimulus(int'($urandom_range(0, 7)), MAXL);

        for (int f = 0; f < 3; f++) applyStimulus(0, MAXL);
        applyStimulus(0, 8);
        checkOutput("locked_before_timeout", int'(locked), 1);
        waitClocks(2 * HSUM - HSUM + 2);
        checkOutput("locked_just_before_timeout", int'(locked), 1);
        waitClocks(3);
        checkOutput("locked_after_timeout", int'(locked), 0);
        checkOutput("de_after_timeout", int'(de), 0);
        acquired = 1'b0;
        goodRun  = 0;
        deTrust  = 1'b0;
        waitClocks(20);

        for (int f = 0; f < 4; f++) applyStimulus(0, MAXL);
        applyStimulus(0, 9);
        checkOutput("locked_before_reset", int'(locked), 1);
        rst = 1'b0;
        #1;
        checkAllClear("mid_frame_reset");
        waitClocks(3);
        rst       = 1'b1;
        acquired  = 1'b0;
        goodRun   = 0;
        prevValid = 1'b0;
        deTrust   = 1'b1;
        waitClocks(3);

        for (int f = 0; f < 4; f++) applyStimulus(0, MAXL);
        applyStimulus(0, 1);
        waitClocks(10);
        checkOutput("scoreboard_drained", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
